// File: rtl/math_challenge_pkg.sv
// Shared types and constants for the math challenge game controller.
package math_challenge_pkg;

  localparam int OPERAND_W = 3;
  localparam int ANS_W     = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN_A    = 3'd1,
    GEN_B    = 3'd2,
    GEN_OP   = 3'd3,
    ASK      = 3'd4,
    FEEDBACK = 3'd5,
    DONE     = 3'd6
  } state_e;

  // Subtraction only ever sees a >= b, so the 4-bit result never wraps.
  function automatic logic [ANS_W-1:0] expected_result(input logic [OPERAND_W-1:0] a,
                                                       input logic [OPERAND_W-1:0] b,
                                                       input logic             sub);
    logic [ANS_W-1:0] res;
    if (sub == OP_SUB) begin
      res = {1'b0, a} - {1'b0, b};
    end else begin
      res = {1'b0, a} + {1'b0, b};
    end
    return res;
  endfunction

endpackage

// File: rtl/challenge_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module challenge_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != {W{1'b0}}) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/challenge_sequencer.sv
// Math challenge game controller: builds questions from the random source,
// takes one answer per question under a timeout and keeps score.
module challenge_sequencer
  import math_challenge_pkg::*;
#(
  parameter int NUM_ROUNDS      = 8,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int FEEDBACK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] rnd_num,
  input  logic [ANS_W-1:0]     answer,
  input  logic                 answer_valid,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  output logic                 op_sub,
  output logic                 question_valid,
  output logic                 answer_ready,
  output logic                 correct,
  output logic                 wrong,
  output logic                 timeout,
  output logic [3:0]           score,
  output logic [3:0]           round,
  output logic                 busy,
  output logic                 done
);

  localparam int         TW         = $clog2(TIMEOUT_CYCLES + FEEDBACK_CYCLES) + 1;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic                 op_sub_q, op_sub_d;
  logic                 qvalid_q, qvalid_d, ready_q, ready_d;
  logic                 correct_q, correct_d, wrong_q, wrong_d, timeout_q, timeout_d;
  logic [3:0]           score_q, score_d, round_q, round_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 accept_s, match_s, expired_s, timer_load_s;
  logic [TW-1:0]        timer_val_s;

  assign accept_s = (state_q == ASK) && answer_valid && ready_q;
  assign match_s  = (answer == expected_result(op_a_q, op_b_q, op_sub_q));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = GEN_A;
        else       state_d = state_q;
      end
      GEN_A:  state_d = GEN_B;
      GEN_B:  state_d = GEN_OP;
      GEN_OP: state_d = ASK;
      ASK: begin
        if (accept_s || expired_s) state_d = FEEDBACK;
        else                       state_d = ASK;
      end
      FEEDBACK: begin
        if (!expired_s)                  state_d = FEEDBACK;
        else if (round_q == LAST_ROUND)  state_d = DONE;
        else                             state_d = GEN_A;
      end
      default: state_d = IDLE;
    endcase
  end

  // One timer serves both the ASK timeout and the FEEDBACK hold.
  assign timer_load_s = (state_d != state_q) && ((state_d == ASK) || (state_d == FEEDBACK));
  assign timer_val_s  = (state_d == ASK) ? TW'(TIMEOUT_CYCLES - 1) : TW'(FEEDBACK_CYCLES - 1);

  challenge_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load_s),
    .load_val_i(timer_val_s),
    .expired_o (expired_s)
  );

  // Operand latches, scoring, round counter and result pulses.
  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_sub_d  = op_sub_q;
    score_d   = score_q;
    round_d   = round_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          score_d = 4'd0;
          round_d = 4'd0;
        end else begin
          score_d = score_q;
        end
      end
      GEN_A: op_a_d = rnd_num;
      GEN_B: op_b_d = rnd_num;
      GEN_OP: begin
        op_sub_d = rnd_num[0];
        if ((rnd_num[0] == OP_SUB) && (op_b_q > op_a_q)) begin
          op_a_d = op_b_q;
          op_b_d = op_a_q;
        end else begin
          op_a_d = op_a_q;
        end
      end
      ASK: begin
        if (accept_s && match_s) begin
          correct_d = 1'b1;
          score_d   = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
        end else if (accept_s) begin
          wrong_d = 1'b1;
        end else if (expired_s) begin
          timeout_d = 1'b1;
        end else begin
          timeout_d = 1'b0;
        end
      end
      FEEDBACK: begin
        if (expired_s && (round_q != LAST_ROUND)) round_d = round_q + 4'd1;
        else                                      round_d = round_q;
      end
      default: round_d = round_q;
    endcase
  end

  // The first ASK cycle only presents the question; answers open one cycle later.
  always_comb begin
    ready_d  = (state_q == ASK) && (state_d == ASK);
    qvalid_d = (state_q inside {ASK, FEEDBACK}) && (state_d inside {ASK, FEEDBACK});
    busy_d   = !(state_d inside {IDLE, DONE});
    done_d   = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_a_q    <= 3'd0;
      op_b_q    <= 3'd0;
      op_sub_q  <= 1'b0;
      qvalid_q  <= 1'b0;
      ready_q   <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      timeout_q <= 1'b0;
      score_q   <= 4'd0;
      round_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_sub_q  <= op_sub_d;
      qvalid_q  <= qvalid_d;
      ready_q   <= ready_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      timeout_q <= timeout_d;
      score_q   <= score_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign op_sub         = op_sub_q;
  assign question_valid = qvalid_q;
  assign answer_ready   = ready_q;
  assign correct        = correct_q;
  assign wrong          = wrong_q;
  assign timeout        = timeout_q;
  assign score          = score_q;
  assign round          = round_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_challenge_sequencer.sv
// Scoreboard bench for challenge_sequencer: directed questions, result pulses checked by a monitor.
module tb_challenge_sequencer;

  localparam int NR = 8;
  localparam int TO = 20;
  localparam int FB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] rnd_num = 3'd0;
  logic [3:0] answer = 4'd0;
  logic       answer_valid = 1'b0;
  logic [2:0] op_a, op_b;
  logic       op_sub, question_valid, answer_ready, correct, wrong, timeout, busy, done;
  logic [3:0] score, round;

  challenge_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO), .FEEDBACK_CYCLES(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .rnd_num(rnd_num), .answer(answer),
    .answer_valid(answer_valid), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .question_valid(question_valid), .answer_ready(answer_ready), .correct(correct),
    .wrong(wrong), .timeout(timeout), .score(score), .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] res;   // {correct, wrong, timeout}
    logic [3:0] score;
    logic [2:0] a;
    logic [2:0] b;
    logic       sub;
    logic [3:0] round;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [2:0] m_a, m_b;
  logic       m_sub;
  logic [3:0] m_score = 4'd0;
  logic [3:0] m_round = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (correct || wrong || timeout) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, correct, wrong, timeout}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {29'd0, correct, wrong, timeout}, {29'd0, e.res});
        check("score", {28'd0, score}, {28'd0, e.score});
        check("op_a", {29'd0, op_a}, {29'd0, e.a});
        check("op_b", {29'd0, op_b}, {29'd0, e.b});
        check("op_sub", {31'd0, op_sub}, {31'd0, e.sub});
        check("round", {28'd0, round}, {28'd0, e.round});
      end
    end
  end

  // Drive the three random values seen in GEN_A, GEN_B and GEN_OP.
  task automatic gen_q(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s);
    int n = 0;
    while (!(busy && !question_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("gen_wait", 32'd0, 32'd1);
    m_sub = s[0];
    if (s[0] && (b > a)) begin
      m_a = b; m_b = a;
    end else begin
      m_a = a; m_b = b;
    end
    rnd_num = a; @(negedge clk);
    rnd_num = b; @(negedge clk);
    rnd_num = s; @(negedge clk);
    rnd_num = 3'd3;
  endtask

  // w < 0: never answer and time the expiry; otherwise answer w cycles after ready opens.
  task automatic answer_q(input logic [3:0] ans, input int w);
    int   n = 0;
    exp_t e;
    logic [3:0] res;
    while (!answer_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_wait", 32'd0, 32'd1);
    if (w < 0) begin
      e = '{res: 3'b001, score: m_score, a: m_a, b: m_b, sub: m_sub, round: m_round};
      sb_q.push_back(e);
      n = 0;
      while (!timeout && n < TO + 10) begin
        @(negedge clk);
        n++;
      end
      check("timeout_latency", n, TO - 1);
    end else begin
      repeat (w) @(negedge clk);
      res = m_sub ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});
      if (ans == res) begin
        m_score = (m_score == 4'd15) ? 4'd15 : m_score + 4'd1;
        e = '{res: 3'b100, score: m_score, a: m_a, b: m_b, sub: m_sub, round: m_round};
      end else begin
        e = '{res: 3'b010, score: m_score, a: m_a, b: m_b, sub: m_sub, round: m_round};
      end
      sb_q.push_back(e);
      answer = ans;
      answer_valid = 1'b1;
      @(negedge clk);
      answer_valid = 1'b0;
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_score = 4'd0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", {31'd0, done}, 32'd1);
  endtask

  // Game 1: a, b, s, answer, answer delay (-1 = let it time out)
  logic [2:0] g1_a [NR] = '{3'd4, 3'd2, 3'd3, 3'd1, 3'd5, 3'd0, 3'd5, 3'd2};
  logic [2:0] g1_b [NR] = '{3'd1, 3'd5, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd2};
  logic [2:0] g1_s [NR] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd5, 3'd1};
  logic [3:0] g1_ans[NR] = '{4'd5, 4'd7, 4'd0, 4'd3, 4'd10, 4'd0, 4'd5, 4'd8};
  int         g1_w  [NR] = '{1, 0, -1, TO - 2, 2, 0, 3, 1};
  // Game 2: every answer right.
  logic [2:0] g2_a [NR] = '{3'd0, 3'd5, 3'd3, 3'd5, 3'd1, 3'd4, 3'd2, 3'd0};
  logic [2:0] g2_b [NR] = '{3'd0, 3'd5, 3'd5, 3'd3, 3'd2, 3'd4, 3'd0, 3'd5};
  logic [2:0] g2_s [NR] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1};
  logic [3:0] g2_ans[NR] = '{4'd0, 4'd10, 4'd2, 4'd2, 4'd3, 4'd0, 4'd2, 4'd5};

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles, stray answers ignored in IDLE.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {op_a, op_b, op_sub, question_valid, answer_ready, correct, wrong,
                            timeout, score, round, busy, done}, 32'd0);
    answer = 4'd5;
    answer_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_pulse", {correct, wrong, timeout, answer_ready, busy}, 32'd0);
    end
    answer_valid = 1'b0;

    // Game 1: add, swapped subtract, timeout, answer on the expiry cycle, then more.
    start_game();
    for (int r = 0; r < NR; r++) begin
      m_round = 4'(r);
      gen_q(g1_a[r], g1_b[r], g1_s[r]);
      answer_q(g1_ans[r], g1_w[r]);
    end
    wait_done();
    check("g1_final", {score, round, busy, done}, {28'd0, 4'd5, 4'd7, 1'b0, 1'b1});

    // Restart from DONE clears score and round at once.
    start_game();
    check("restart", {score, round, busy, done}, {28'd0, 4'd0, 4'd0, 1'b1, 1'b0});
    for (int r = 0; r < NR; r++) begin
      m_round = 4'(r);
      gen_q(g2_a[r], g2_b[r], g2_s[r]);
      answer_q(g2_ans[r], r % 3);
    end
    wait_done();
    check("g2_final", {score, round, busy, done}, {28'd0, 4'd8, 4'd7, 1'b0, 1'b1});

    // Game 3: start while busy is ignored; reset mid-question.
    start_game();
    for (int r = 0; r < 3; r++) begin
      m_round = 4'(r);
      gen_q(g2_a[r], g2_b[r], g2_s[r]);
      if (r == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {round, score, busy}, {23'd0, 4'd1, 4'd1, 1'b1});
      end
      answer_q(g2_ans[r], 1);
    end
    m_round = 4'd3;
    gen_q(3'd1, 3'd1, 3'd0);
    while (!answer_ready) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset", {answer_ready, question_valid, busy, done, score, round},
          {28'd0, 4'd0} >> 0);
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, correct, wrong, timeout}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
